// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers returned
// words with their PCs and presents one instruction per cycle to the IF/ID register.
module fetch_stage #(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F
);

  localparam int          CW      = $clog2(2 * DEPTH + 1);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [31:0]   pc_r;
  logic [31:0]   buf_pc_r    [DEPTH];
  logic [31:0]   buf_instr_r [DEPTH];
  logic [PW-1:0] buf_rd_r;
  logic [PW-1:0] buf_wr_r;
  logic [CW-1:0] occ_r;
  logic [31:0]   tag_r       [DEPTH];
  logic [PW-1:0] tag_rd_r;
  logic [PW-1:0] tag_wr_r;
  logic [CW-1:0] live_r;
  logic [CW-1:0] drop_r;

  logic          valid_s;
  logic          req_s;
  logic          accept_s;
  logic          resp_drop_s;
  logic          resp_keep_s;
  logic          pop_s;
  logic [CW:0]   credit_use_s;

  // Handshake decode; credits count only registered occupancy and outstanding requests.
  always_comb begin
    valid_s      = (occ_r != CW'(0));
    credit_use_s = {1'b0, occ_r} + {1'b0, live_r};
    req_s        = reset & ~BranchTakenE & (credit_use_s < DEPTH_C);
    accept_s     = req_s & imem_ready_i;
    // Stale words are always consumed first; rvalid with nothing outstanding is ignored.
    resp_drop_s  = imem_rvalid_i & (drop_r != CW'(0));
    resp_keep_s  = imem_rvalid_i & (drop_r == CW'(0)) & (live_r != CW'(0));
    pop_s        = valid_s & ~StallF & ~BranchTakenE;
  end

  // PC, request-tag FIFO, instruction buffer and outstanding/stale counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r     <= RESET_VECTOR;
      buf_rd_r <= '0;
      buf_wr_r <= '0;
      occ_r    <= '0;
      tag_rd_r <= '0;
      tag_wr_r <= '0;
      live_r   <= '0;
      drop_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_r[i]    <= 32'h0000_0000;
        buf_instr_r[i] <= 32'h0000_0000;
        tag_r[i]       <= 32'h0000_0000;
      end
    end else if (BranchTakenE) begin
      pc_r     <= BranchTargetE & 32'hFFFF_FFFC;
      buf_rd_r <= '0;
      buf_wr_r <= '0;
      occ_r    <= '0;
      tag_rd_r <= '0;
      tag_wr_r <= '0;
      live_r   <= '0;
      // Everything still live becomes stale, less any word landing this very cycle.
      drop_r   <= drop_r - CW'(resp_drop_s) + live_r - CW'(resp_keep_s);
    end else begin
      if (accept_s) begin
        tag_r[tag_wr_r] <= pc_r;
        tag_wr_r        <= ptr_inc(tag_wr_r);
        pc_r            <= pc_r + 32'd4;
      end
      if (resp_keep_s) begin
        buf_pc_r[buf_wr_r]    <= tag_r[tag_rd_r];
        buf_instr_r[buf_wr_r] <= imem_rdata_i;
        buf_wr_r              <= ptr_inc(buf_wr_r);
        tag_rd_r              <= ptr_inc(tag_rd_r);
      end
      if (pop_s) begin
        buf_rd_r <= ptr_inc(buf_rd_r);
      end
      occ_r  <= occ_r + CW'(resp_keep_s) - CW'(pop_s);
      live_r <= live_r + CW'(accept_s) - CW'(resp_keep_s);
      drop_r <= drop_r - CW'(resp_drop_s);
    end
  end

  // Buffer head drives the decode-facing outputs; a bubble when the buffer is empty.
  always_comb begin
    imem_req_o  = req_s;
    imem_addr_o = pc_r;
    InstrValidF = valid_s;
    if (valid_s) begin
      InstrF = buf_instr_r[buf_rd_r];
      PCF    = buf_pc_r[buf_rd_r];
    end else begin
      InstrF = NOP_INSTR;
      PCF    = 32'h0000_0000;
    end
    PCPlus4F = PCF + 32'd4;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random traffic,
// compared every cycle against a queue-based transaction model with an in-order memory.
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  fetch_stage #(.DEPTH(DEPTH), .RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .BranchTakenE  (BranchTakenE),
    .BranchTargetE (BranchTargetE),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .InstrF        (InstrF),
    .InstrValidF   (InstrValidF),
    .PCF           (PCF),
    .PCPlus4F      (PCPlus4F)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ent_t        m_buf[$];
  logic [31:0] m_tag[$];
  int          m_drop;
  logic [31:0] m_pc;
  mreq_t       mq[$];
  int          now;
  int          total;
  int          bad;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic cyc(input bit rn, input bit st, input bit br, input logic [31:0] tg,
                     input bit rdy, input int lat, input bit spur);
    bit          from_q;
    bit          e_req;
    bit          e_val;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    bit          acc;
    bit          keep;
    logic [31:0] kpc;
    logic [31:0] issued;
    @(negedge clk);
    reset         = rn;
    StallF        = st;
    BranchTakenE  = br;
    BranchTargetE = tg;
    imem_ready_i  = rdy;
    from_q        = 1'b0;
    if (!rn) begin
      m_buf.delete();
      m_tag.delete();
      m_drop = 0;
      m_pc   = RV;
      mq.delete();
    end
    if (rn && mq.size() > 0 && mq[0].due <= now) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mq[0].addr);
      from_q        = 1'b1;
    end else if (rn && spur && mq.size() == 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = $urandom;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    e_req = rn && !br && (m_buf.size() + m_tag.size() < DEPTH);
    e_val = m_buf.size() > 0;
    e_ins = e_val ? m_buf[0].ins : NOP;
    e_pc  = e_val ? m_buf[0].pc : 32'h0;
    chk("req", {31'b0, imem_req_o}, {31'b0, e_req});
    chk("addr", imem_addr_o, m_pc);
    chk("valid", {31'b0, InstrValidF}, {31'b0, e_val});
    chk("instr", InstrF, e_ins);
    chk("pcf", PCF, e_pc);
    chk("pcplus4", PCPlus4F, e_pc + 32'd4);
    @(posedge clk);
    if (rn) begin
      acc  = e_req && rdy;
      keep = 1'b0;
      kpc  = 32'h0;
      if (imem_rvalid_i) begin
        if (m_drop > 0) begin
          m_drop--;
        end else if (m_tag.size() > 0) begin
          kpc  = m_tag.pop_front();
          keep = 1'b1;
        end
      end
      if (br) begin
        m_buf.delete();
        m_drop += m_tag.size();
        m_tag.delete();
        m_pc = tg & 32'hFFFF_FFFC;
      end else begin
        if (e_val && !st) void'(m_buf.pop_front());
        if (keep) m_buf.push_back('{pc: kpc, ins: imem_rdata_i});
        if (acc) begin
          m_tag.push_back(m_pc);
          issued = m_pc;
          m_pc   = m_pc + 32'd4;
        end
      end
      if (from_q) void'(mq.pop_front());
      if (acc && !br) mq.push_back('{addr: issued, due: now + lat});
    end
    now++;
  endtask

  task automatic seek(input logic [31:0] target, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_buf.size() > 0 && m_buf[0].pc == target) found = 1'b1;
      else cyc(1, 0, 0, 0, 1, 1, 0);
    end
    chk(tag, {31'b0, found}, 32'h1);
  endtask

  initial begin
    total = 0; bad = 0; now = 0;
    m_drop = 0; m_pc = RV;
    reset = 1'b0; StallF = 1'b0; BranchTakenE = 1'b0; BranchTargetE = 32'h0;
    imem_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;

    // Reset held three cycles, then plain streaming from the reset vector.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 1, 0);

    // Stall with PCF at 0x8 (re-reached after a redirect back to 0).
    cyc(1, 0, 1, 32'h0, 1, 1, 0);
    seek(32'h8, "seek_pc8");
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 1, 0);

    // Slow memory builds two outstanding requests, then redirect to 0x100.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 3, 0);
    cyc(1, 0, 1, 32'h100, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 1, 1, 0);

    // Unaligned target, redirect under stall, and spurious responses.
    cyc(1, 1, 1, 32'h203, 1, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1, 1, 1);

    // Memory not ready for three cycles.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 1, 0);

    // Reset mid-stream at PCF=0x20, then restart from the reset vector.
    cyc(1, 0, 1, 32'h10, 1, 1, 0);
    seek(32'h20, "seek_pc20");
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1, 1, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 149) != 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 11) == 0,
          $urandom,
          $urandom_range(0, 3) != 0,
          $urandom_range(1, 3),
          $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
